// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: sys_clk-side command sequencer that turns spi_byte bytes into single-byte bus transactions.
// Define SPI_CMD_AUTOINC_EN to enable WRITE_NEXT/READ_NEXT; ADDR_WIDTH must be at least 17.
module spi_cmd_ctrl #(
  parameter int ADDR_WIDTH  = 17,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic                  spi_cs_n,
  input  logic                  spi_done,
  input  logic [7:0]            spi_rx_data,
  output logic [7:0]            spi_tx_data,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [7:0]            bus_wr_data,
  input  logic                  bus_ack,
  input  logic [7:0]            bus_rd_data,
  output logic                  busy,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_DATA,
    S_BUS,
    S_ERR
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0]  done_sync_q, done_sync_d;
  logic                    cs_prev_q, cs_prev_d;
  logic                    done_prev_q, done_prev_d;
  logic                    bus_req_q, bus_req_d;
  logic                    bus_we_q, bus_we_d;
  logic [ADDR_WIDTH-1:0]   bus_addr_q, bus_addr_d;
  logic [7:0]              bus_wr_data_q, bus_wr_data_d;
  logic [7:0]              spi_tx_data_q, spi_tx_data_d;
  logic                    busy_q, busy_d;
  logic                    error_q, error_d;
`ifdef SPI_CMD_AUTOINC_EN
  logic [ADDR_WIDTH-1:0]   stored_addr_q, stored_addr_d;
`endif

  logic cs_s;
  logic done_s;
  logic byte_valid;
  logic cs_fall;

  // Both synchronisers reset to 1 so the idle-high lines never look like an edge after reset.
  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    done_sync_d = {done_sync_q[SYNC_STAGES-2:0], spi_done};
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    done_s      = done_sync_q[SYNC_STAGES-1];
    cs_prev_d   = cs_s;
    done_prev_d = done_s;
    byte_valid  = done_s & ~done_prev_q & ~cs_s;
    cs_fall     = cs_prev_q & ~cs_s;
  end

  always_comb begin
    state_d       = state_q;
    bus_req_d     = bus_req_q;
    bus_we_d      = bus_we_q;
    bus_addr_d    = bus_addr_q;
    bus_wr_data_d = bus_wr_data_q;
    spi_tx_data_d = spi_tx_data_q;
    error_d       = error_q;
`ifdef SPI_CMD_AUTOINC_EN
    stored_addr_d = stored_addr_q;
`endif
    if (cs_fall) begin
      error_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (byte_valid) begin
          if (!spi_rx_data[7]) begin
            bus_we_d       = ~spi_rx_data[6];
            bus_addr_d     = '0;
            bus_addr_d[16] = spi_rx_data[0];
            state_d        = S_ADDR_HI;
          end else begin
`ifdef SPI_CMD_AUTOINC_EN
            bus_we_d   = ~spi_rx_data[6];
            bus_addr_d = stored_addr_q + ADDR_WIDTH'(1);
            state_d    = spi_rx_data[6] ? S_BUS : S_DATA;
`else
            error_d = 1'b1;
            state_d = S_ERR;
`endif
          end
        end
      end
      S_ADDR_HI: begin
        if (cs_s) begin
          state_d = S_IDLE;
        end else if (byte_valid) begin
          bus_addr_d[15:8] = spi_rx_data;
          state_d          = S_ADDR_LO;
        end
      end
      S_ADDR_LO: begin
        if (cs_s) begin
          state_d = S_IDLE;
        end else if (byte_valid) begin
          bus_addr_d[7:0] = spi_rx_data;
          state_d         = bus_we_q ? S_DATA : S_BUS;
        end
      end
      S_DATA: begin
        if (cs_s) begin
          state_d = S_IDLE;
        end else if (byte_valid) begin
          bus_wr_data_d = spi_rx_data;
          state_d       = S_BUS;
        end
      end
      // Once here the transaction always completes, regardless of cs_n or further bytes.
      S_BUS: begin
        if (bus_req_q && bus_ack) begin
          bus_req_d = 1'b0;
          if (!bus_we_q) begin
            spi_tx_data_d = bus_rd_data;
          end
`ifdef SPI_CMD_AUTOINC_EN
          stored_addr_d = bus_addr_q;
`endif
          state_d = S_IDLE;
        end else begin
          bus_req_d = 1'b1;
        end
      end
      S_ERR: begin
        if (cs_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cs_sync_q     <= '1;
      done_sync_q   <= '1;
      cs_prev_q     <= 1'b1;
      done_prev_q   <= 1'b1;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_wr_data_q <= '0;
      spi_tx_data_q <= '0;
      busy_q        <= 1'b0;
      error_q       <= 1'b0;
`ifdef SPI_CMD_AUTOINC_EN
      stored_addr_q <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cs_sync_q     <= cs_sync_d;
      done_sync_q   <= done_sync_d;
      cs_prev_q     <= cs_prev_d;
      done_prev_q   <= done_prev_d;
      bus_req_q     <= bus_req_d;
      bus_we_q      <= bus_we_d;
      bus_addr_q    <= bus_addr_d;
      bus_wr_data_q <= bus_wr_data_d;
      spi_tx_data_q <= spi_tx_data_d;
      busy_q        <= busy_d;
      error_q       <= error_d;
`ifdef SPI_CMD_AUTOINC_EN
      stored_addr_q <= stored_addr_d;
`endif
    end
  end

  assign spi_tx_data = spi_tx_data_q;
  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wr_data = bus_wr_data_q;
  assign busy        = busy_q;
  assign error       = error_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Scoreboard bench for spi_cmd_ctrl: stimulus pushes expected bus transactions, a monitor pops and checks them.
// Auto-increment scenarios run only when SPI_CMD_AUTOINC_EN is defined; otherwise the illegal-command path is exercised.
`timescale 1ns/1ps
module tb_spi_cmd_ctrl;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        spi_cs_n;
  logic        spi_done;
  logic [7:0]  spi_rx_data;
  logic [7:0]  spi_tx_data;
  logic        bus_req;
  logic        bus_we;
  logic [16:0] bus_addr;
  logic [7:0]  bus_wr_data;
  logic        bus_ack;
  logic [7:0]  bus_rd_data;
  logic        busy;
  logic        error;

  typedef struct packed {
    logic        we;
    logic [16:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
  } txn_t;

  txn_t       exp_q[$];
  int         checks = 0;
  int         fails = 0;
  int         ack_delay = 3;
  logic [7:0] rd_value = 8'h00;
  bit         in_txn = 1'b0;

  always #5 sys_clk = ~sys_clk;

  spi_cmd_ctrl dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .spi_cs_n    (spi_cs_n),
    .spi_done    (spi_done),
    .spi_rx_data (spi_rx_data),
    .spi_tx_data (spi_tx_data),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wr_data (bus_wr_data),
    .bus_ack     (bus_ack),
    .bus_rd_data (bus_rd_data),
    .busy        (busy),
    .error       (error)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // One SPI byte as spi_byte presents it: done low while shifting, then data valid on the done rise.
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge sys_clk);
    spi_done = 1'b0;
    repeat (3) @(negedge sys_clk);
    spi_rx_data = b;
    spi_done    = 1'b1;
    repeat (6) @(negedge sys_clk);
  endtask

  task automatic csLow();
    @(negedge sys_clk);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic csHigh();
    @(negedge sys_clk);
    spi_cs_n = 1'b1;
    repeat (5) @(negedge sys_clk);
  endtask

  task automatic expectTxn(input logic we, input logic [16:0] addr, input logic [7:0] wdata,
                           input logic [7:0] rdata, input int delay);
    txn_t t;
    t.we    = we;
    t.addr  = addr;
    t.wdata = wdata;
    t.rdata = rdata;
    exp_q.push_back(t);
    ack_delay = delay;
    rd_value  = rdata;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while ((busy || in_txn) && n < 300) begin
      @(negedge sys_clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      fails++;
      $display("[TB] FAIL %s: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  // Arbiter model: acknowledges each request ack_delay cycles after it is first seen.
  initial begin
    bus_ack     = 1'b0;
    bus_rd_data = 8'h00;
    forever begin
      @(negedge sys_clk);
      if (bus_req && !reset) begin
        repeat (ack_delay - 1) @(negedge sys_clk);
        bus_rd_data = rd_value;
        bus_ack     = 1'b1;
        @(negedge sys_clk);
        bus_ack = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard when a request appears and follows it to its ack.
  initial begin
    txn_t cur;
    int   held;
    cur  = '0;
    held = 0;
    forever begin
      @(posedge sys_clk);
      #1;
      if (reset) begin
        in_txn = 1'b0;
      end else if (!in_txn) begin
        if (bus_req) begin
          in_txn = 1'b1;
          held   = 0;
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL unexpected_req: got bus_req=1 addr=0x%0h, required no request", bus_addr);
            cur    = '0;
            cur.we = 1'b1;
          end else begin
            cur = exp_q.pop_front();
            checkOutput("bus_we", {31'b0, bus_we}, {31'b0, cur.we});
            checkOutput("bus_addr", {15'b0, bus_addr}, {15'b0, cur.addr});
            if (cur.we) begin
              checkOutput("bus_wr_data", {24'b0, bus_wr_data}, {24'b0, cur.wdata});
            end
          end
        end
      end else begin
        if (bus_ack) begin
          checkOutput("req_drop_after_ack", {31'b0, bus_req}, 32'd0);
          checkOutput("busy_drop_after_ack", {31'b0, busy}, 32'd0);
          if (!cur.we) begin
            checkOutput("spi_tx_data", {24'b0, spi_tx_data}, {24'b0, cur.rdata});
          end
          in_txn = 1'b0;
        end else begin
          held++;
          checkOutput("req_held", {31'b0, bus_req}, 32'd1);
          if (held > 100) begin
            checkOutput("ack_timeout", held, 32'd100);
            in_txn = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #200us;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    spi_cs_n    = 1'b1;
    spi_done    = 1'b1;
    spi_rx_data = 8'h00;
    repeat (4) @(negedge sys_clk);
    reset = 1'b0;
    repeat (3) @(negedge sys_clk);
    checkOutput("rst_bus_req", {31'b0, bus_req}, 32'd0);
    checkOutput("rst_bus_we", {31'b0, bus_we}, 32'd0);
    checkOutput("rst_bus_addr", {15'b0, bus_addr}, 32'd0);
    checkOutput("rst_bus_wr_data", {24'b0, bus_wr_data}, 32'd0);
    checkOutput("rst_spi_tx_data", {24'b0, spi_tx_data}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_error", {31'b0, error}, 32'd0);

    $display("[TB] WRITE 0x18000 <= 0xA5");
    expectTxn(1'b1, 17'h18000, 8'hA5, 8'h00, 3);
    csLow();
    applyStimulus(8'h01);
    checkOutput("busy_after_cmd", {31'b0, busy}, 32'd1);
    applyStimulus(8'h80);
    applyStimulus(8'h00);
    applyStimulus(8'hA5);
    waitIdle("write_done");
    csHigh();

    $display("[TB] READ 0x0E810");
    expectTxn(1'b0, 17'h0E810, 8'h00, 8'h5A, 2);
    csLow();
    applyStimulus(8'h40);
    applyStimulus(8'hE8);
    applyStimulus(8'h10);
    waitIdle("read_done");
    csHigh();

`ifdef SPI_CMD_AUTOINC_EN
    $display("[TB] READ_NEXT -> 0x0E811");
    expectTxn(1'b0, 17'h0E811, 8'h00, 8'h3C, 2);
    csLow();
    applyStimulus(8'hC0);
    waitIdle("read_next_done");
    csHigh();

    $display("[TB] READ 0x1FFFF then WRITE_NEXT wraps to 0");
    expectTxn(1'b0, 17'h1FFFF, 8'h00, 8'h11, 1);
    csLow();
    applyStimulus(8'h41);
    applyStimulus(8'hFF);
    applyStimulus(8'hFF);
    waitIdle("read_top_done");
    expectTxn(1'b1, 17'h00000, 8'h77, 8'h00, 2);
    applyStimulus(8'h80);
    applyStimulus(8'h77);
    waitIdle("write_next_wrap_done");
    csHigh();
`endif

    $display("[TB] abort after two bytes");
    csLow();
    applyStimulus(8'h00);
    applyStimulus(8'h12);
    csHigh();
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    checkOutput("abort_no_req", {31'b0, bus_req}, 32'd0);
    expectTxn(1'b1, 17'h01234, 8'h56, 8'h00, 1);
    csLow();
    applyStimulus(8'h00);
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    applyStimulus(8'h56);
    waitIdle("post_abort_write_done");
    csHigh();

    $display("[TB] cs_n rise during BUS with slow ack");
    expectTxn(1'b0, 17'h00022, 8'h00, 8'h99, 10);
    csLow();
    applyStimulus(8'h40);
    applyStimulus(8'h00);
    applyStimulus(8'h22);
    @(negedge sys_clk);
    spi_cs_n = 1'b1;
    waitIdle("bus_abort_done");
    repeat (5) @(negedge sys_clk);

`ifndef SPI_CMD_AUTOINC_EN
    $display("[TB] illegal command without auto-increment");
    csLow();
    applyStimulus(8'h80);
    checkOutput("illegal_error_set", {31'b0, error}, 32'd1);
    applyStimulus(8'h11);
    checkOutput("illegal_no_req", {31'b0, bus_req}, 32'd0);
    csHigh();
    checkOutput("illegal_back_idle", {31'b0, busy}, 32'd0);
    checkOutput("illegal_error_sticky", {31'b0, error}, 32'd1);
    csLow();
    checkOutput("illegal_error_cleared", {31'b0, error}, 32'd0);
    csHigh();
`endif

    csLow();
    csHigh();
    checkOutput("tx_data_held", {24'b0, spi_tx_data}, 32'h99);
    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
